// File: rtl/program_sequencer_pkg.sv
// Shared CPU definitions: op codes, instruction field positions and event-bit indices.
package program_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_MOV = 3'd1,
        OP_ACC = 3'd2,
        OP_JMP = 3'd3,
        OP_ATC = 3'd4
    } op_e;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 29;
    localparam int SUB_MSB    = 28;
    localparam int SUB_LSB    = 26;
    localparam int TARGET_MSB = 7;
    localparam int TARGET_LSB = 0;

    // Event bits 7:4 are external pulses; SHFT is the first of them.
    localparam logic [2:0] EV_SHFT = 3'd4;

    function automatic logic [2:0] op_of(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] sub_of(input logic [31:0] word);
        return word[SUB_MSB:SUB_LSB];
    endfunction

    function automatic logic [7:0] target_of(input logic [31:0] word);
        return word[TARGET_MSB:TARGET_LSB];
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction-memory side of the sequencer: fetch address out, word and flow controls in.
interface program_sequencer_if;
    logic [31:0] instruction;
    logic        cond_true;
    logic        stall;
    logic [7:0]  address;
    logic        exec_en;

    // No handshake: the word for `address` is valid combinationally in the same cycle.
    modport master (input instruction, cond_true, stall, output address, exec_en);
    modport slave  (output instruction, cond_true, stall, input address, exec_en);
endinterface

// File: rtl/program_sequencer_key_event_sync.sv
// Two-flop key synchronizer plus press detector; one press pulse per release->press cycle.
module key_event_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_n,
    output logic [W-1:0] press
);
    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] armed;
    logic [1:0]   valid;

    // A key must be seen released from a real pin sample before it can arm, so a key
    // held through reset (flops preset to "released") does not fake an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= '1;
            sync  <= '1;
            armed <= '0;
            valid <= '0;
        end else begin
            meta  <= key_n;
            sync  <= meta;
            valid <= {valid[0], 1'b1};
            armed <= (armed | ({W{valid[1]}} & sync)) & ~press;
        end
    end

    assign press = armed & ~sync;

endmodule

// File: rtl/program_sequencer.sv
// Instruction pointer sequencer with event register and conditional / event-driven jumps.
module program_sequencer
    import program_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    program_sequencer_if.master   bus,
    input  logic [3:0]            key_n,
    input  logic [3:0]            ev_set,
    output logic [7:0]            pending
);
    logic [7:0] ip;
    logic [7:0] ip_next;
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [3:0] key_press;
    logic [2:0] op;
    logic [2:0] sub;
    logic [7:0] target;
    logic       unused_fields;

    assign op            = op_of(bus.instruction);
    assign sub           = sub_of(bus.instruction);
    assign target        = target_of(bus.instruction);
    assign unused_fields = ^bus.instruction[25:8];

    key_event_sync #(.W(4)) u_key_sync (
        .clk   (clk),
        .rst   (reset),
        .key_n (key_n),
        .press (key_press)
    );

    always_comb begin
        ip_next  = ip + 8'd1;
        clr_bits = '0;
        case (op)
            OP_JMP: if (bus.cond_true) ip_next = target;
            OP_ATC: begin
                if (pending[sub]) begin
                    ip_next       = target;
                    clr_bits[sub] = 1'b1;
                end
            end
            default: ;
        endcase
        if (bus.stall) begin
            ip_next  = ip;
            clr_bits = '0;
        end
    end

    assign set_bits = {ev_set, key_press};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ip <= '0;
        else       ip <= ip_next;
    end

    // Set after clear so a new event in the same cycle as its ATC is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~clr_bits) | set_bits;
    end

    assign bus.address = ip;
    assign bus.exec_en = ((op == OP_MOV) || (op == OP_ACC)) && !bus.stall && !reset;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios then randomized instruction flow.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] ev_set;
    logic [7:0] pending;

    program_sequencer_if bus();

    program_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .key_n   (key_n),
        .ev_set  (ev_set),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] m_ip;
    logic [7:0] m_pend;
    logic [3:0] m_armed;
    logic [3:0] smp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [2:0] op, input logic [2:0] sub,
                                         input logic [7:0] tgt);
        return {op, sub, 18'd0, tgt};
    endfunction

    function automatic logic is_exec_op(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2);
    endfunction

    // One clock: compare outputs at negedge, then advance the model across the posedge.
    task automatic tick();
        logic [7:0] nip;
        logic [7:0] nclr;
        logic [7:0] nset;
        logic [3:0] press;
        logic [3:0] arrive;
        logic [2:0] op;
        logic [2:0] sub;
        logic [7:0] tgt;
        @(negedge clk);
        op  = bus.instruction[31:29];
        sub = bus.instruction[28:26];
        tgt = bus.instruction[7:0];
        check("address", {24'd0, bus.address}, {24'd0, m_ip});
        check("exec_en", {31'd0, bus.exec_en}, {31'd0, is_exec_op(op) && !bus.stall});
        check("pending", {24'd0, pending}, {24'd0, m_pend});

        // Key samples emerge from a two-deep delay line; a 0 counts as a press only
        // if a released sample has emerged since the last press.
        press = '0;
        smp_q.push_back(key_n);
        if (smp_q.size() == 3) begin
            arrive = smp_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                if (arrive[i]) m_armed[i] = 1'b1;
                else if (m_armed[i]) begin
                    press[i]   = 1'b1;
                    m_armed[i] = 1'b0;
                end
            end
        end
        nset = {ev_set, press};
        nclr = '0;
        nip  = m_ip + 8'd1;
        if (bus.stall) nip = m_ip;
        else if (op == 3'd3 && bus.cond_true) nip = tgt;
        else if (op == 3'd4 && m_pend[sub]) begin
            nip       = tgt;
            nclr[sub] = 1'b1;
        end
        @(posedge clk);
        #1;
        m_ip   = nip;
        m_pend = (m_pend & ~nclr) | nset;
    endtask

    // Asynchronous reset pulse away from any edge, with a MOV under stall driven.
    task automatic do_reset();
        @(negedge clk);
        bus.instruction = word(3'd1, 3'd0, 8'd0);
        bus.stall       = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("reset_address", {24'd0, bus.address}, 32'd0);
        check("reset_pending", {24'd0, pending}, 32'd0);
        check("reset_exec_en", {31'd0, bus.exec_en}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.instruction = '0;
        bus.stall       = 1'b0;
        m_ip    = '0;
        m_pend  = '0;
        m_armed = '0;
        smp_q.delete();
    endtask

    task automatic goto_ip(input logic [7:0] ip);
        bus.instruction = word(3'd3, 3'd0, ip);
        bus.cond_true   = 1'b1;
        bus.stall       = 1'b0;
        tick();
        bus.instruction = '0;
        bus.cond_true   = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        key_n           = 4'hF;
        ev_set          = 4'h0;
        bus.instruction = '0;
        bus.cond_true   = 1'b0;
        bus.stall       = 1'b0;
        m_ip    = '0;
        m_pend  = '0;
        m_armed = '0;
        #1 reset = 1'b1;
        do_reset();

        // NOP stream wraps 255 -> 0
        repeat (258) tick();
        check("nop_wrap_address", {24'd0, bus.address}, 32'd2);
        do_reset();

        // ATC bit 3 not pending falls through; after a press it jumps and clears
        goto_ip(8'd85);
        bus.instruction = word(OP_ATC, 3'd3, 8'd10);
        tick();
        check("atc_not_pending", {24'd0, bus.address}, 32'd86);
        goto_ip(8'd85);
        bus.instruction = word(OP_ATC, 3'd3, 8'd10);
        bus.stall = 1'b1;
        key_n[3]  = 1'b0;
        repeat (4) tick();
        check("key3_latency", {31'd0, pending[3]}, 32'd1);
        check("stall_hold_85", {24'd0, bus.address}, 32'd85);
        bus.stall = 1'b0;
        tick();
        check("atc_taken_addr", {24'd0, bus.address}, 32'd10);
        check("atc_taken_clear", {31'd0, pending[3]}, 32'd0);
        key_n[3] = 1'b1;

        // JMP with cond false then true
        goto_ip(8'd40);
        bus.instruction = word(OP_JMP, 3'd0, 8'd84);
        bus.cond_true   = 1'b0;
        tick();
        check("jmp_not_taken", {24'd0, bus.address}, 32'd41);
        bus.cond_true = 1'b1;
        tick();
        check("jmp_taken", {24'd0, bus.address}, 32'd84);

        // ATC clear of bit 2 coinciding with a new key-2 press: set wins
        bus.stall = 1'b1;
        key_n[2]  = 1'b0;
        repeat (4) tick();
        key_n[2] = 1'b1;
        repeat (3) tick();
        goto_ip(8'd50);
        bus.stall = 1'b1;
        key_n[2]  = 1'b0;
        repeat (2) tick();
        bus.instruction = word(OP_ATC, 3'd2, 8'd60);
        bus.stall = 1'b0;
        tick();
        check("atc_collide_addr", {24'd0, bus.address}, 32'd60);
        check("atc_collide_keep", {31'd0, pending[2]}, 32'd1);
        key_n[2] = 1'b1;
        bus.instruction = '0;

        // Stalled MOV at 11
        goto_ip(8'd11);
        bus.instruction = word(OP_MOV, 3'd0, 8'd0);
        bus.stall = 1'b1;
        repeat (5) tick();
        check("stall_mov_addr", {24'd0, bus.address}, 32'd11);
        check("stall_mov_exec", {31'd0, bus.exec_en}, 32'd0);
        bus.stall = 1'b0;
        #1 check("mov_exec_on", {31'd0, bus.exec_en}, 32'd1);
        tick();
        bus.instruction = '0;
        #1;
        check("mov_advance", {24'd0, bus.address}, 32'd12);
        check("mov_exec_off", {31'd0, bus.exec_en}, 32'd0);

        // ev_set[0] -> pending[4], consumed by ATC SHFT
        ev_set = 4'b0001;
        tick();
        ev_set = 4'b0000;
        check("ev_shft_set", {31'd0, pending[4]}, 32'd1);
        bus.instruction = word(OP_ATC, EV_SHFT, 8'd17);
        tick();
        check("atc_shft_addr", {24'd0, bus.address}, 32'd17);
        check("atc_shft_clear", {31'd0, pending[4]}, 32'd0);
        bus.instruction = '0;

        // Held key sets only once
        key_n[1] = 1'b0;
        repeat (6) tick();
        check("held_key_set", {31'd0, pending[1]}, 32'd1);
        bus.instruction = word(OP_ATC, 3'd1, 8'd30);
        tick();
        bus.instruction = '0;
        repeat (6) tick();
        check("held_key_once", {31'd0, pending[1]}, 32'd0);
        key_n[1] = 1'b1;

        // Reset while a key is held: no event until release and re-press
        key_n[0] = 1'b0;
        do_reset();
        repeat (8) tick();
        check("reset_midpress_quiet", {31'd0, pending[0]}, 32'd0);
        key_n[0] = 1'b1;
        repeat (3) tick();
        key_n[0] = 1'b0;
        repeat (4) tick();
        check("repress_after_reset", {31'd0, pending[0]}, 32'd1);
        key_n[0] = 1'b1;

        // Randomized instruction flow
        repeat (500) begin
            bus.instruction = $urandom();
            bus.cond_true   = 1'($urandom_range(0, 1));
            bus.stall       = ($urandom_range(0, 3) == 0);
            ev_set          = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 149) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
